cpu_wb: RTL
===========

CPU_WB -- requirements
Module: cpu_wb

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 16, meaning the maximum number of WAIT_LOAD cycles before a load is abandoned.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the datapath width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mem_valid  input  1  MEM stage presents an instruction.
REQ-007 mem_ready  output  1  WB accepts the instruction; transfer occurs when mem_valid && mem_ready.
REQ-008 WBcontrols  input  2  {memToReg, writeEnable}, as bundled by decode.
REQ-009 dst_reg  input  4  destination register address.
REQ-010 alu_result  input  DATA_W  EX/MEM result.
REQ-011 halt  input  1  the instruction being offered is HLT.
REQ-012 mem_rd_data  input  DATA_W  load data from data memory.
REQ-013 mem_rd_valid  input  1  mem_rd_data is valid this cycle.
REQ-014 wrData  output  DATA_W  register-file write data.
REQ-015 regWriteIncomingAddr  output  4  register-file write address.
REQ-016 regWriteControl  output  1  register-file write enable, single-cycle pulse.
REQ-017 halted  output  1  the core has retired HLT.
REQ-018 load_err  output  1  sticky flag: a load timed out.
REQ-019 retire_count  output  16  number of instructions retired.

Function
REQ-020 FSM states and transitions SHALL be:
- IDLE -> WRITE on accepting a non-load (memToReg=0).
- IDLE -> WAIT_LOAD on accepting a load (memToReg=1).
- IDLE -> HALTED on accepting an instruction with halt=1.
- WAIT_LOAD -> WRITE on mem_rd_valid.
- WRITE -> IDLE unconditionally.
REQ-021 mem_ready SHALL be 1 only in IDLE.
REQ-022 Non-load timing: regWriteControl SHALL pulse in the cycle after acceptance, with wrData=alu_result captured at acceptance.
REQ-023 Load timing: regWriteControl SHALL pulse in the cycle after mem_rd_valid, with wrData=mem_rd_data captured on mem_rd_valid.
REQ-024 regWriteControl SHALL be writeEnable && (dst_reg != 0); writes to R0 are suppressed, but the instruction still retires.
REQ-025 mem_rd_valid SHALL be ignored outside WAIT_LOAD, including in the load's own acceptance cycle.
REQ-026 Load timeout: WAIT_LOAD SHALL return to IDLE after LOAD_TIMEOUT cycles without mem_rd_valid; in that case load_err is set, no write occurs, and no retire is counted.
REQ-027 retire_count SHALL increment by 1 in each WRITE cycle and in the cycle HALTED is entered; it wraps from 0xFFFF to 0x0000.
REQ-028 HALTED SHALL be terminal until reset: halted=1, mem_ready=0, no writes.
REQ-029 halt=1 SHALL take priority over memToReg at acceptance.

Reset
REQ-030 While rst is high, the FSM SHALL be in IDLE and all outputs SHALL be 0 except mem_ready, which is 1 after rst deasserts.
REQ-031 Reset asserted in WAIT_LOAD or WRITE SHALL abort the instruction with no write pulse; load_err, halted and retire_count clear.

Configuration
REQ-032 Macro WB_FWD_EN defined: the block SHALL add outputs fwd_valid (1), fwd_reg (4) and fwd_data (DATA_W), driven combinationally equal to regWriteControl, regWriteIncomingAddr and wrData, so decode can bypass a same-cycle write.
REQ-033 Macro WB_FWD_EN undefined: those ports SHALL be absent, and decode relies on write-before-read in the register file.

Structure
REQ-034 Shared package cpu_pkg SHALL hold the wb_state_t enum (IDLE, WAIT_LOAD, WRITE, HALTED), the WBcontrols bit indices (WB_MEMTOREG=1, WB_WREN=0) and REG_ZERO=4'h0.
REQ-035 The timeout counter SHALL be sub-module wb_timeout_ctr, with inputs clear/enable and output expired.

Verification
REQ-036 Scenario: non-load, dst=3, alu_result=0x1234, writeEnable=1 -> next cycle regWriteControl=1, addr=3, wrData=0x1234; retire_count=1.
REQ-037 Scenario: load to R5 with mem_rd_valid 4 cycles later and data 0xBEEF -> mem_ready=0 for 4 cycles; write to R5 of 0xBEEF one cycle after valid.
REQ-038 Scenario: load, no mem_rd_valid for 16 cycles -> load_err=1, no write, back in IDLE, retire_count unchanged.
REQ-039 Scenario: dst=0, writeEnable=1 -> regWriteControl stays 0; retire_count increments.
REQ-040 Scenario: HLT accepted -> halted=1, mem_ready=0 thereafter; rst pulse -> halted=0, mem_ready=1, retire_count=0.
REQ-041 Scenario: rst asserted mid-WAIT_LOAD, then mem_rd_valid -> no write pulse; FSM in IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback FSM states, WBcontrols bit positions and the
// hard-wired zero register address.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2,
    HALTED    = 2'd3
  } wb_state_t;

  localparam int WB_MEMTOREG = 1;
  localparam int WB_WREN     = 0;

  localparam logic [3:0] REG_ZERO = 4'h0;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Load-wait watchdog: a down-counter reloaded while cleared. expired is high in the
// last permitted wait cycle, so the wait lasts exactly LOAD_TIMEOUT cycles.
module wb_timeout_ctr #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW       = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= LOAD_VAL;
    end else if (clear) begin
      r_cnt <= LOAD_VAL;
    end else if (enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign expired = enable && (r_cnt == '0);

endmodule

// File: rtl/cpu_wb.sv
// Writeback stage: accepts one instruction at a time from MEM, waits for load data
// with a timeout, and pulses the register-file write. Optional WB_FWD_EN adds bypass outputs.
//   state     | meaning
//   IDLE      | ready for the next instruction from MEM
//   WAIT_LOAD | load accepted, waiting on mem_rd_valid (bounded by LOAD_TIMEOUT)
//   WRITE     | one-cycle register-file write slot; instruction retires
//   HALTED    | HLT retired, nothing more is accepted until reset
module cpu_wb
  import cpu_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [1:0]        WBcontrols,
  input  logic [3:0]        dst_reg,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              halt,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [DATA_W-1:0] wrData,
  output logic [3:0]        regWriteIncomingAddr,
  output logic              regWriteControl,
  output logic              halted,
  output logic              load_err,
  output logic [15:0]       retire_count
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [3:0]        fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  wb_state_t         r_state;
  wb_state_t         w_next;
  logic              w_accept;
  logic              w_rd_take;
  logic              w_expired;
  logic              w_timeout;
  logic              w_retire;
  logic [DATA_W-1:0] r_wr_data;
  logic [3:0]        r_addr;
  logic              r_we;
  logic              r_load_err;
  logic [15:0]       r_retire;

  assign w_accept  = mem_valid && mem_ready;
  assign w_rd_take = (r_state == WAIT_LOAD) && mem_rd_valid;
  assign w_timeout = (r_state == WAIT_LOAD) && !mem_rd_valid && w_expired;
  assign w_retire  = (w_next == WRITE) || ((r_state == IDLE) && (w_next == HALTED));

  wb_timeout_ctr #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (r_state != WAIT_LOAD),
    .enable (r_state == WAIT_LOAD),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (halt)                          w_next = HALTED;
          else if (WBcontrols[WB_MEMTOREG])  w_next = WAIT_LOAD;
          else                               w_next = WRITE;
        end
      end
      WAIT_LOAD: begin
        if (mem_rd_valid)   w_next = WRITE;
        else if (w_expired) w_next = IDLE;
      end
      WRITE:   w_next = IDLE;
      HALTED:  w_next = HALTED;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_ready       = 1'b0;
    regWriteControl = 1'b0;
    halted          = 1'b0;
    case (r_state)
      IDLE:    mem_ready       = !rst;
      WRITE:   regWriteControl = r_we;
      HALTED:  halted          = 1'b1;
      default: ;
    endcase
  end

  // R0 suppression is folded into the captured write enable at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_data  <= '0;
      r_addr     <= REG_ZERO;
      r_we       <= 1'b0;
      r_load_err <= 1'b0;
      r_retire   <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_wr_data <= alu_result;
        r_addr    <= dst_reg;
        r_we      <= WBcontrols[WB_WREN] && (dst_reg != REG_ZERO);
      end
      if (w_rd_take) begin
        r_wr_data <= mem_rd_data;
      end
      if (w_timeout) begin
        r_load_err <= 1'b1;
      end
      if (w_retire) begin
        r_retire <= r_retire + 16'd1;
      end
    end
  end

  assign wrData               = r_wr_data;
  assign regWriteIncomingAddr = r_addr;
  assign load_err             = r_load_err;
  assign retire_count         = r_retire;

`ifdef WB_FWD_EN
  assign fwd_valid = regWriteControl;
  assign fwd_reg   = regWriteIncomingAddr;
  assign fwd_data  = wrData;
`endif

endmodule
